microcode_sequencer: RTL and testbench

MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

---
 rtl/microcode_sequencer.sv | 138 +++++++++++++
 tb/tb_microcode_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// Two-phase microcode sequencer: fetches a 16-bit control word from a pair of
// ROMs addressed by {IR, STEP, FL}, then applies its END/IR_LOAD/HALT_REQ bits.
module microcode_sequencer (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  IR_IN,
    input  logic        FLAG,
    input  logic [7:0]  D0,
    input  logic [7:0]  D1,
    output logic [12:0] A,
    output logic        nCE,
    output logic        nOE,
    output logic        nWE,
    output logic [15:0] CW,
    output logic        CW_VALID,
    output logic        HALT,
    output logic        OVF,
    output logic [3:0]  STEP
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_EXEC   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_ir;
    logic [3:0]  r_step;
    logic        r_fl;
    logic [15:0] r_cw;
    logic        r_ovf;
    logic        r_nce;
    logic        r_noe;
    logic        r_cw_valid;
    logic        r_halt;
    logic        w_strobe_nxt;
    logic        w_valid_nxt;
    logic        w_halt_nxt;
    logic        w_end;
    logic        w_ir_load;
    logic        w_halt_req;

    assign w_end      = r_cw[15];
    assign w_ir_load  = r_cw[14];
    assign w_halt_req = r_cw[13];

    // Next-state selection and decode of the registered strobes from the next state
    always_comb begin
        w_state_nxt  = r_state;
        w_strobe_nxt = 1'b1;
        w_valid_nxt  = 1'b0;
        w_halt_nxt   = 1'b0;
        case (r_state)
            S_IDLE:   w_state_nxt = S_READ;
            S_READ:   w_state_nxt = S_EXEC;
            S_EXEC: begin
                if (w_halt_req) begin
                    w_state_nxt = S_HALTED;
                end else begin
                    w_state_nxt = S_READ;
                end
            end
            S_HALTED: w_state_nxt = S_HALTED;
            default:  w_state_nxt = S_IDLE;
        endcase
        case (w_state_nxt)
            S_READ:   w_strobe_nxt = 1'b0;
            S_EXEC:   w_valid_nxt  = 1'b1;
            S_HALTED: w_halt_nxt   = 1'b1;
            default:  w_strobe_nxt = 1'b1;
        endcase
    end

    // State register and registered ROM strobes / status outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_nce      <= 1'b1;
            r_noe      <= 1'b1;
            r_cw_valid <= 1'b0;
            r_halt     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_nce      <= w_strobe_nxt;
            r_noe      <= w_strobe_nxt;
            r_cw_valid <= w_valid_nxt;
            r_halt     <= w_halt_nxt;
        end
    end

    // Datapath: flag latch, control-word capture and microstep/IR update
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ir   <= 8'h00;
            r_step <= 4'd0;
            r_fl   <= 1'b0;
            r_cw   <= 16'h0000;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: r_fl <= FLAG;
                S_READ: r_cw <= {D1, D0};
                S_EXEC: begin
                    r_fl <= FLAG;
                    // A halt request freezes IR and STEP at the halting microstep
                    if (!w_halt_req) begin
                        if (w_end) begin
                            r_step <= 4'd0;
                        end else begin
                            r_step <= r_step + 4'd1;
                            if (r_step == 4'd15) begin
                                r_ovf <= 1'b1;
                            end
                        end
                        if (w_ir_load) begin
                            r_ir <= IR_IN;
                        end
                    end
                end
                default: r_cw <= r_cw;
            endcase
        end
    end

    assign A        = {r_ir, r_step, r_fl};
    assign nCE      = r_nce;
    assign nOE      = r_noe;
    assign nWE      = 1'b1;
    assign CW       = r_cw;
    assign CW_VALID = r_cw_valid;
    assign HALT     = r_halt;
    assign OVF      = r_ovf;
    assign STEP     = r_step;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed and randomized bench for microcode_sequencer with a microstep-level
// reference model (IR, step counter, latched flag, sticky overflow).
module tb_microcode_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  IR_IN = 8'h00;
    logic        FLAG = 1'b0;
    logic [7:0]  D0 = 8'h00;
    logic [7:0]  D1 = 8'h00;
    logic [12:0] A;
    logic        nCE, nOE, nWE;
    logic [15:0] CW;
    logic        CW_VALID, HALT, OVF;
    logic [3:0]  STEP;

    int checks = 0;
    int errors = 0;

    int       m_ir;
    int       m_step;
    int       m_fl;
    int       m_ovf;

    microcode_sequencer dut (
        .CLK(CLK), .RST(RST), .IR_IN(IR_IN), .FLAG(FLAG), .D0(D0), .D1(D1),
        .A(A), .nCE(nCE), .nOE(nOE), .nWE(nWE), .CW(CW), .CW_VALID(CW_VALID),
        .HALT(HALT), .OVF(OVF), .STEP(STEP)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_a"}, 32'(A), 32'h0);
        chk({tag, "_cw"}, 32'(CW), 32'h0);
        chk({tag, "_valid"}, 32'(CW_VALID), 32'h0);
        chk({tag, "_halt"}, 32'(HALT), 32'h0);
        chk({tag, "_ovf"}, 32'(OVF), 32'h0);
        chk({tag, "_strobes"}, {29'h0, nCE, nOE, nWE}, 32'h7);
        chk({tag, "_step"}, 32'(STEP), 32'h0);
    endtask

    // Reset, release, pass through IDLE and arrive in the first READ cycle
    task automatic do_reset(input logic flg);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk_reset("rst");
        RST = 1'b0;
        FLAG = flg;
        m_ir = 0; m_step = 0; m_fl = 0; m_ovf = 0;
        chk("idle_nce", 32'(nCE), 32'h1);
        @(posedge CLK); #1;
        m_fl = int'(flg);
    endtask

    // One microstep starting from a READ cycle; returns in the following READ (or HALTED)
    task automatic micro(input logic [15:0] cw, input logic [7:0] irin, input logic flg);
        chk("rd_addr", 32'(A), 32'(m_ir * 32 + m_step * 2 + m_fl));
        chk("rd_strobes", {29'h0, nCE, nOE, nWE}, 32'h1);
        chk("rd_valid", 32'(CW_VALID), 32'h0);
        chk("rd_step", 32'(STEP), 32'(m_step));
        chk("rd_ovf", 32'(OVF), 32'(m_ovf));
        {D1, D0} = cw;
        FLAG = 1'($urandom);
        IR_IN = 8'($urandom);
        @(posedge CLK); #1;
        chk("ex_cw", 32'(CW), 32'(cw));
        chk("ex_valid", 32'(CW_VALID), 32'h1);
        chk("ex_strobes", {29'h0, nCE, nOE, nWE}, 32'h7);
        IR_IN = irin;
        FLAG = flg;
        {D1, D0} = 16'($urandom);
        @(posedge CLK); #1;
        if (cw[13] == 1'b0) begin
            if (cw[15]) m_step = 0;
            else begin
                m_step = (m_step + 1) % 16;
                if (m_step == 0) m_ovf = 1;
            end
            if (cw[14]) m_ir = int'(irin);
        end
        m_fl = int'(flg);
    endtask

    initial begin
        // Basic END loop at address zero
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) micro(16'h8000, 8'($urandom), 1'b0);
        chk("end_loop_a", 32'(A), 32'h0000);

        // IR load without END advances to step 1 of the new opcode
        do_reset(1'b0);
        micro(16'h4000, 8'hA5, 1'b0);
        chk("irload_a", 32'(A), 32'h14A2);

        // END plus IR load with FLAG set
        micro(16'hC000, 8'h3C, 1'b1);
        chk("end_irload_a", 32'(A), 32'h0781);
        chk("end_irload_step", 32'(STEP), 32'h0);

        // Sixteen plain microsteps wrap STEP and set the sticky overflow
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("wrap_step", 32'(STEP), 32'(i));
            micro(16'h0000, 8'h00, 1'b0);
        end
        chk("wrap_ovf", 32'(OVF), 32'h1);
        chk("wrap_step0", 32'(STEP), 32'h0);
        micro(16'h8000, 8'h00, 1'b0);
        chk("ovf_sticky", 32'(OVF), 32'h1);

        // Randomized microsteps without halt requests
        do_reset(1'($urandom));
        for (int i = 0; i < 60; i++) begin
            micro(16'($urandom) & 16'hDFFF, 8'($urandom), 1'($urandom));
        end

        // Halt holds off all ROM activity until reset
        micro(16'h2000, 8'h77, 1'b1);
        for (int i = 0; i < 22; i++) begin
            chk("halt_flag", 32'(HALT), 32'h1);
            chk("halt_strobes", {29'h0, nCE, nOE, nWE}, 32'h7);
            chk("halt_valid", 32'(CW_VALID), 32'h0);
            chk("halt_cw", 32'(CW), 32'h2000);
            @(posedge CLK); #1;
        end
        do_reset(1'b0);

        // Asynchronous reset in the middle of EXEC discards the IR load
        {D1, D0} = 16'h4000;
        @(posedge CLK); #1;
        chk("mid_cw", 32'(CW), 32'h4000);
        IR_IN = 8'h5A;
        #1 RST = 1'b1;
        #1 chk_reset("async");
        @(posedge CLK); #1;
        RST = 1'b0;
        FLAG = 1'b0;
        @(posedge CLK); #1;
        chk("post_async_a", 32'(A), 32'h0000);
        chk("post_async_nce", 32'(nCE), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
